// File: rtl/tx_flow_control_window.sv
// tx_flow_control_window
//   Transmit-side flow control gate for a CHDR link. Limits the number of
//   unacknowledged data packets in flight to a programmable window, consumes
//   the downstream consumer's ACK packets, and stamps each outgoing header
//   with a contiguous 12-bit sequence number (tracked as a 32-bit count).
//
// Ports
//   clk, reset_n (async, active low), clear (sync)
//   set_stb/set_addr/set_data : settings bus; window register at SR_FLOW_CTRL_WINDOW
//                               (bit31 enable, bits15:0 window)
//   i_t*                      : CHDR data in (i_tready is an output)
//   o_t*                      : CHDR data out, header seqnum rewritten (o_tready is an input)
//   fc_t*                     : flow control packets in; fc_tready=1 outside reset
//   in_flight                 : next_seq - last_ack - 1 (mod 2^32)
//   ack_err                   : one-cycle pulse when an ACK is rejected
module tx_flow_control_window #(
  parameter int unsigned SR_FLOW_CTRL_WINDOW = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [63:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [63:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  input  logic [63:0] fc_tdata,
  input  logic        fc_tlast,
  input  logic        fc_tvalid,
  output logic        fc_tready,
  output logic [31:0] in_flight,
  output logic        ack_err
);

  localparam logic [7:0] SR_ADDR = SR_FLOW_CTRL_WINDOW[7:0];

  typedef enum logic {D_HDR, D_BODY} dstate_t;
  typedef enum logic [1:0] {F_HDR, F_TIME, F_PAYLOAD, F_DRAIN} fstate_t;

  dstate_t     r_dstate;
  fstate_t     r_fstate;
  logic        r_win_en;
  logic [15:0] r_win;
  logic [31:0] r_next_seq;
  logic [31:0] r_last_ack;
  logic        r_ack_err;

  logic [31:0] w_in_flight;
  logic        w_go;
  logic        w_hdr;
  logic        w_pass;
  logic        w_d_hs;
  logic        w_fc_hs;
  logic        w_ack_beat;
  logic [31:0] w_ack;
  logic [31:0] w_ack_d;
  logic        w_ack_ok;
  logic        w_ack_bad;
  logic        w_unused_bits;

  // last_ack starts at all-ones so the unsigned difference is 0 out of reset
  assign w_in_flight = r_next_seq - r_last_ack - 32'd1;
  assign w_go        = !r_win_en || (w_in_flight < {16'd0, r_win});
  assign w_hdr       = (r_dstate == D_HDR);
  // Gate applies only at packet start; body beats always flow.
  // Held closed during reset so nothing leaks out while state is cleared.
  assign w_pass      = reset_n && (!w_hdr || w_go);

  assign o_tvalid  = i_tvalid && w_pass;
  assign i_tready  = o_tready && w_pass;
  assign o_tlast   = i_tlast;
  assign o_tdata   = w_hdr ? {i_tdata[63:60], r_next_seq[11:0], i_tdata[47:0]} : i_tdata;
  assign fc_tready = reset_n;
  assign in_flight = w_in_flight;
  assign ack_err   = r_ack_err;

  assign w_d_hs  = i_tvalid && i_tready;
  assign w_fc_hs = fc_tvalid && fc_tready;

  // Only the tlast payload beat carries the ACK that counts
  assign w_ack_beat = w_fc_hs && (r_fstate == F_PAYLOAD) && fc_tlast;
  assign w_ack      = fc_tdata[31:0];
  assign w_ack_d    = w_ack - r_last_ack;
  // Judged against pre-update in_flight even if a header passes this cycle
  assign w_ack_ok   = w_ack_beat && (w_ack_d != 32'd0) && (w_ack_d <= w_in_flight);
  assign w_ack_bad  = w_ack_beat && (w_ack_d != 32'd0) && (w_ack_d >  w_in_flight);

  assign w_unused_bits = ^{fc_tdata[60:32], set_data[30:16]};

  // Window register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_win_en <= 1'b0;
      r_win    <= 16'd0;
    end else if (set_stb && (set_addr == SR_ADDR)) begin
      r_win_en <= set_data[31];
      r_win    <= set_data[15:0];
    end
  end

  // Data FSM and sequence counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dstate   <= D_HDR;
      r_next_seq <= 32'd0;
    end else if (clear) begin
      r_dstate   <= D_HDR;
      r_next_seq <= 32'd0;
    end else if (w_d_hs) begin
      if (r_dstate == D_HDR) begin
        r_next_seq <= r_next_seq + 32'd1;
        if (!i_tlast) r_dstate <= D_BODY;
      end else if (i_tlast) begin
        r_dstate <= D_HDR;
      end
    end
  end

  // Flow control FSM and ACK tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fstate   <= F_HDR;
      r_last_ack <= 32'hFFFF_FFFF;
      r_ack_err  <= 1'b0;
    end else if (clear) begin
      r_fstate   <= F_HDR;
      r_last_ack <= 32'hFFFF_FFFF;
      r_ack_err  <= 1'b0;
    end else begin
      r_ack_err <= w_ack_bad;
      if (w_ack_ok) r_last_ack <= w_ack;
      if (w_fc_hs) begin
        case (r_fstate)
          F_HDR: begin
            // A one-beat packet carries no payload: nothing to do
            if (fc_tlast)                       r_fstate <= F_HDR;
            else if (fc_tdata[63:62] != 2'b01)  r_fstate <= F_DRAIN;
            else if (fc_tdata[61])              r_fstate <= F_TIME;
            else                                r_fstate <= F_PAYLOAD;
          end
          F_TIME:    r_fstate <= fc_tlast ? F_HDR : F_PAYLOAD;
          F_PAYLOAD: if (fc_tlast) r_fstate <= F_HDR;
          F_DRAIN:   if (fc_tlast) r_fstate <= F_HDR;
          default:   r_fstate <= F_HDR;
        endcase
      end
    end
  end

endmodule
